layer_axis_tx: RTL and testbench

//  Transmit side of the network's AXI-Stream datapath. Captures the parallel

---
 rtl/layer_axis_tx_pkg.sv | 17 +
 rtl/layer_axis_tx_argmax_track.sv | 50 +++++
 rtl/layer_axis_tx.sv | 123 ++++++++++++
 tb/tb_layer_axis_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/layer_axis_tx_pkg.sv
// rtl/layer_axis_tx_pkg.sv - shared types and sizing helpers for the layer AXI-Stream transmitter
package layer_axis_tx_pkg;

  localparam int NN_DEFAULT         = 4;
  localparam int DATA_WIDTH_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Beat counter / argmax index width; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_axis_tx_argmax_track.sv
// rtl/layer_axis_tx_argmax_track.sv - running signed max and index over the beats of one packet
module layer_axis_tx_argmax_track #(
  parameter int DATA_WIDTH = 16,
  parameter int IDXW       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  update,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [IDXW-1:0]       idx,
  output logic [IDXW-1:0]       max_idx,
  output logic                  max_valid
);

  logic signed [DATA_WIDTH-1:0] run_max;
  logic [IDXW-1:0]              run_idx;
  logic                         take;
  logic [IDXW-1:0]              next_idx;

  // The first beat of a packet always seeds the max; afterwards only a
  // strictly greater value replaces it, so ties keep the lower index.
  always_comb begin
    take     = clear || ($signed(value) > run_max);
    next_idx = take ? idx : run_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max   <= '0;
      run_idx   <= '0;
      max_idx   <= '0;
      max_valid <= 1'b0;
    end else begin
      max_valid <= 1'b0;
      if (update) begin
        if (take) begin
          run_max <= $signed(value);
          run_idx <= idx;
        end
        if (done) begin
          max_idx   <= next_idx;
          max_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/layer_axis_tx.sv
// rtl/layer_axis_tx.sv - serializes the final layer output vector onto an AXI-Stream master and tracks its argmax
module layer_axis_tx
  import layer_axis_tx_pkg::*;
#(
  parameter int  NN         = NN_DEFAULT,
  parameter int  DATA_WIDTH = DATA_WIDTH_DEFAULT,
  localparam int IDXW       = idx_width(NN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     x_valid,
  input  logic [NN*DATA_WIDTH-1:0] x_in,
  output logic [DATA_WIDTH-1:0]    axis_out_data,
  output logic                     axis_out_valid,
  input  logic                     axis_out_ready,
  output logic                     axis_out_last,
  output logic [IDXW-1:0]          max_idx,
  output logic                     max_valid,
  output logic                     overflow,
  output logic                     busy
);

  localparam logic [IDXW-1:0] LAST_LANE = IDXW'(NN - 1);
  localparam logic            ONE_LANE  = (NN == 1);

  state_t                  state;
  logic [NN*DATA_WIDTH-1:0] hold;
  logic [NN*DATA_WIDTH-1:0] pend;
  logic                    pend_full;
  logic [IDXW-1:0]         cnt;
  logic [IDXW-1:0]         next_cnt;
  logic                    fire;
  logic                    final_fire;

  always_comb begin
    fire       = axis_out_valid && axis_out_ready;
    final_fire = fire && (cnt == LAST_LANE);
    next_cnt   = cnt + IDXW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      hold           <= '0;
      pend           <= '0;
      pend_full      <= 1'b0;
      cnt            <= '0;
      axis_out_data  <= '0;
      axis_out_valid <= 1'b0;
      axis_out_last  <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (x_valid) begin
            hold           <= x_in;
            cnt            <= '0;
            axis_out_data  <= x_in[DATA_WIDTH-1:0];
            axis_out_valid <= 1'b1;
            axis_out_last  <= ONE_LANE;
            state          <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (final_fire) begin
            // Packet boundary: chain the next vector with no idle beat.
            if (pend_full) begin
              hold          <= pend;
              axis_out_data <= pend[DATA_WIDTH-1:0];
              cnt           <= '0;
              axis_out_last <= ONE_LANE;
              if (x_valid) pend <= x_in;
              else         pend_full <= 1'b0;
            end else if (x_valid) begin
              hold          <= x_in;
              axis_out_data <= x_in[DATA_WIDTH-1:0];
              cnt           <= '0;
              axis_out_last <= ONE_LANE;
            end else begin
              state          <= ST_IDLE;
              axis_out_valid <= 1'b0;
              axis_out_last  <= 1'b0;
              cnt            <= '0;
            end
          end else begin
            if (fire) begin
              cnt           <= next_cnt;
              axis_out_data <= hold[next_cnt*DATA_WIDTH +: DATA_WIDTH];
              axis_out_last <= (next_cnt == LAST_LANE);
            end
            if (x_valid) begin
              if (!pend_full) begin
                pend      <= x_in;
                pend_full <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_SEND) || pend_full;

  layer_axis_tx_argmax_track #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDXW       (IDXW)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt == '0),
    .update    (fire),
    .done      (final_fire),
    .value     (axis_out_data),
    .idx       (cnt),
    .max_idx   (max_idx),
    .max_valid (max_valid)
  );

endmodule

// File: tb/tb_layer_axis_tx.sv
// tb/tb_layer_axis_tx.sv - scoreboard bench for layer_axis_tx with NN=4, 16-bit lanes
module tb_layer_axis_tx;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_valid;
  logic [63:0] x_in;
  logic [15:0] axis_out_data;
  logic        axis_out_valid;
  logic        axis_out_ready;
  logic        axis_out_last;
  logic [1:0]  max_idx;
  logic        max_valid;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int beats = 0;
  int maxp = 0;
  int b0;
  int m0;

  beat_t      sb[$];
  logic [1:0] mq[$];

  layer_axis_tx dut (
    .clk            (clk),
    .rst            (rst),
    .x_valid        (x_valid),
    .x_in           (x_in),
    .axis_out_data  (axis_out_data),
    .axis_out_valid (axis_out_valid),
    .axis_out_ready (axis_out_ready),
    .axis_out_last  (axis_out_last),
    .max_idx        (max_idx),
    .max_valid      (max_valid),
    .overflow       (overflow),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference argmax: signed, strictly greater replaces.
  function automatic logic [1:0] model_argmax(input logic [63:0] v);
    logic signed [15:0] best;
    logic [1:0] bi;
    best = $signed(v[15:0]);
    bi   = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if ($signed(v[i*16 +: 16]) > best) begin
        best = $signed(v[i*16 +: 16]);
        bi   = 2'(i);
      end
    end
    return bi;
  endfunction

  task automatic push_vec(input logic [63:0] v);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.d = v[i*16 +: 16];
      b.l = (i == 3);
      sb.push_back(b);
    end
    mq.push_back(model_argmax(v));
  endtask

  task automatic monitor();
    beat_t e;
    if (axis_out_valid === 1'b1 && axis_out_ready === 1'b1) begin
      beats++;
      check("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("beat_data", 32'(axis_out_data), 32'(e.d));
        check("beat_last", 32'(axis_out_last), 32'(e.l));
      end
    end
    if (max_valid === 1'b1) begin
      maxp++;
      check("max_expected", 32'(mq.size() != 0), 32'd1);
      if (mq.size() != 0) check("max_idx", 32'(max_idx), 32'(mq.pop_front()));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] v, input logic expect_accept);
    x_valid = 1'b1;
    x_in    = v;
    if (expect_accept) push_vec(v);
    cycle();
    x_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"}, 32'(axis_out_data), 32'd0);
    check({tag, "_valid"}, 32'(axis_out_valid), 32'd0);
    check({tag, "_last"}, 32'(axis_out_last), 32'd0);
    check({tag, "_max_idx"}, 32'(max_idx), 32'd0);
    check({tag, "_max_valid"}, 32'(max_valid), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    x_valid        = 1'b0;
    x_in           = '0;
    axis_out_ready = 1'b1;
    #2;
    check_idle_outputs("reset");
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // In-order lanes, ready held high, one-cycle latency.
    drive(pack4(16'd1, 16'd2, 16'd3, 16'd4), 1'b1);
    check("t2_lat_valid", 32'(axis_out_valid), 32'd1);
    check("t2_lat_data", 32'(axis_out_data), 32'd1);
    check("t2_lat_last", 32'(axis_out_last), 32'd0);
    cycle();
    cycle();
    cycle();
    check("t2_last_on_lane3", 32'(axis_out_last), 32'd1);
    check("t2_data_lane3", 32'(axis_out_data), 32'd4);
    cycle();
    check("t2_max_valid", 32'(max_valid), 32'd1);
    check("t2_max_idx", 32'(max_idx), 32'd3);
    check("t2_idle_valid", 32'(axis_out_valid), 32'd0);
    cycle();
    check("t2_max_pulse", 32'(max_valid), 32'd0);
    check("t2_max_hold", 32'(max_idx), 32'd3);
    check("t2_drained", 32'(sb.size()), 32'd0);

    // Backpressure holds the current beat stable.
    b0 = beats;
    drive(pack4(16'd1, 16'd2, 16'd3, 16'd4), 1'b1);
    cycle();
    axis_out_ready = 1'b0;
    cycle();
    check("t3_stall1_valid", 32'(axis_out_valid), 32'd1);
    check("t3_stall1_data", 32'(axis_out_data), 32'd2);
    cycle();
    check("t3_stall2_data", 32'(axis_out_data), 32'd2);
    axis_out_ready = 1'b1;
    cycle();
    cycle();
    cycle();
    check("t3_beat_count", 32'(beats - b0), 32'd4);
    cycle();
    cycle();
    check("t3_drained", 32'(sb.size()), 32'd0);

    // Back-to-back vectors, third dropped while pending is full.
    b0 = beats;
    drive(pack4(16'd1, 16'd2, 16'd3, 16'd4), 1'b1);
    cycle();
    drive(pack4(16'd5, 16'd6, 16'd7, 16'd8), 1'b1);
    check("t4_overflow_before", 32'(overflow), 32'd0);
    drive(pack4(16'd9, 16'd10, 16'd11, 16'd12), 1'b0);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) cycle();
    check("t4_no_bubble", 32'(beats - b0), 32'd8);
    for (int i = 0; i < 4; i++) cycle();
    check("t4_overflow_sticky", 32'(overflow), 32'd1);
    check("t4_drained", 32'(sb.size() + mq.size()), 32'd0);

    // Reset while idle clears sticky overflow and all outputs.
    rst = 1'b1;
    #2;
    check_idle_outputs("t1_reset");
    rst = 1'b0;
    cycle();

    // Signed compare with a tie.
    drive(pack4(16'hFFFF, 16'h0005, 16'h0005, 16'h8000), 1'b1);
    for (int i = 0; i < 6; i++) cycle();
    check("t5_max_idx", 32'(max_idx), 32'd1);
    check("t5_drained", 32'(sb.size() + mq.size()), 32'd0);

    // Reset mid-packet drops the rest of the vector.
    b0 = beats;
    m0 = maxp;
    drive(pack4(16'd21, 16'd22, 16'd23, 16'd24), 1'b1);
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(axis_out_valid), 32'd0);
    sb.delete();
    mq.delete();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    check("t6_beats", 32'(beats - b0), 32'd2);
    check("t6_no_max_valid", 32'(maxp - m0), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_valid", 32'(axis_out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
